// File: rtl/fetch_pc_unit.sv
// Program counter owner and IF/ID register: fetch handshake, redirects, bubbles, stall buffering.
// Optional BRANCH_DELAY_SLOT_EN: if_flush is ignored on redirect so the delay-slot instruction is kept.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch issued
// FETCH | request outstanding at pc
// HOLD  | fetched word parked in buffer while ID is stalled
// DRAIN | waiting out an abandoned fetch before jumping to redir_pc
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_src,
    input  logic        if_flush,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    input  logic [31:0] jr_target,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        redir;
    logic        redir_flush;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        bubble;
    logic        load_mem;
    logic        load_buf;

    assign redir    = (pc_src != 2'b00) && !id_stall;
    assign pc_plus4 = pc_q + 32'd4;

`ifdef BRANCH_DELAY_SLOT_EN
    assign redir_flush = 1'b0;
`else
    assign redir_flush = if_flush;
`endif

    always_comb begin
        target = pc_plus4;
        case (pc_src)
            2'b01:   target = j_target;
            2'b10:   target = br_target;
            2'b11:   target = jr_target;
            default: target = pc_plus4;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        buf_instr_d  = buf_instr_q;
        buf_pc4_d    = buf_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        bubble       = 1'b0;
        load_mem     = 1'b0;
        load_buf     = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
                bubble  = !id_stall;
            end
            FETCH: begin
                if (imem_ready) begin
                    if (redir) begin
                        pc_d = target;
                        if (redir_flush) bubble = 1'b1;
                        else             load_mem = 1'b1;
                    end else if (!id_stall) begin
                        pc_d = pc_plus4;
                        if (if_flush) bubble = 1'b1;
                        else          load_mem = 1'b1;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = pc_plus4;
                        state_d     = HOLD;
                    end
                end else if (redir) begin
                    redir_pc_d = target;
                    bubble     = 1'b1;
                    state_d    = DRAIN;
                end else begin
                    bubble = !id_stall;
                end
            end
            HOLD: begin
                if (!id_stall) begin
                    state_d = FETCH;
                    if (redir) begin
                        pc_d = target;
                        if (redir_flush) bubble = 1'b1;
                        else             load_buf = 1'b1;
                    end else begin
                        pc_d     = pc_plus4;
                        load_buf = 1'b1;
                    end
                end
            end
            DRAIN: begin
                bubble = !id_stall;
                if (redir) redir_pc_d = target;
                // A redirect arriving on the completing cycle is the latest one, so it wins.
                if (imem_ready) begin
                    pc_d    = redir ? target : redir_pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase

        if (load_mem) begin
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end else if (load_buf) begin
            ifid_instr_d = buf_instr_q;
            ifid_pc4_d   = buf_pc4_q;
            ifid_valid_d = 1'b1;
        end else if (bubble) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            redir_pc_q   <= 32'h0;
            buf_instr_q  <= 32'h0;
            buf_pc4_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc4_q    <= buf_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Request is suppressed while reset is applied so an in-flight fetch is abandoned at once.
    assign imem_req    = !rst && ((state_q == FETCH) || (state_q == DRAIN));
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_instr = ifid_instr_q;
    assign if_id_pc4   = ifid_pc4_q;
    assign if_id_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: expectations queued per cycle, checked after the edge.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_src = 2'b00;
    logic        if_flush = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] j_target = 32'h0;
    logic [31:0] jr_target = 32'h0;
    logic        id_stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    fetch_pc_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .if_flush(if_flush),
        .br_target(br_target), .j_target(j_target), .jr_target(jr_target),
        .id_stall(id_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = instr_at(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0: return {31'b0, imem_req};
            1: return imem_addr;
            2: return if_id_instr;
            3: return if_id_pc4;
            4: return {31'b0, if_id_valid};
            default: return pc;
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = kind; e.val = v;
        sb.push_back(e);
    endtask

    task automatic exp_fetch(input string tag, input logic req, input logic [31:0] addr);
        push({tag, ".req"}, 0, {31'b0, req});
        push({tag, ".addr"}, 1, addr);
        push({tag, ".pc"}, 5, addr);
    endtask

    task automatic exp_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4, input logic v);
        push({tag, ".instr"}, 2, ins);
        push({tag, ".pc4"}, 3, p4);
        push({tag, ".valid"}, 4, {31'b0, v});
    endtask

    // Drive one cycle of inputs at negedge, clock it, then compare queued expectations.
    task automatic cyc(input logic rdy, input logic stl, input logic [1:0] src,
                       input logic fl, input logic [31:0] tgt);
        exp_t e;
        imem_ready = rdy;
        id_stall   = stl;
        pc_src     = src;
        if_flush   = fl;
        j_target   = 32'hBAD0_0001;
        br_target  = 32'hBAD0_0002;
        jr_target  = 32'hBAD0_0003;
        case (src)
            2'b01: j_target  = tgt;
            2'b10: br_target = tgt;
            2'b11: jr_target = tgt;
            default: ;
        endcase
        @(posedge clk);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic release_reset(input string tag);
        rst = 1'b0;
        #1;
        check_eq({tag, ".boot_req"}, {31'b0, imem_req}, 32'h0);
    endtask

    logic [31:0] held_pc4;

    initial begin
        // reset
        @(negedge clk);
        exp_fetch("rst", 1'b0, RST_PC);
        exp_ifid("rst", NOP, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
        release_reset("t1");

        // test 1: boot then sequential fetch
        exp_fetch("t1.boot", 1'b1, 32'h100);
        exp_ifid("t1.boot", NOP, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
        exp_fetch("t1.f0", 1'b1, 32'h104);
        exp_ifid("t1.f0", instr_at(32'h100), 32'h104, 1'b1);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
        exp_fetch("t1.f1", 1'b1, 32'h108);
        exp_ifid("t1.f1", instr_at(32'h104), 32'h108, 1'b1);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);

        // jump to 0x200 without flush keeps current instruction
        exp_fetch("jmp200", 1'b1, 32'h200);
        exp_ifid("jmp200", instr_at(32'h108), 32'h10C, 1'b1);
        cyc(1'b1, 1'b0, 2'b01, 1'b0, 32'h200);

        // test 2: branch with flush
        exp_fetch("t2", 1'b1, 32'h400);
`ifdef BRANCH_DELAY_SLOT_EN
        exp_ifid("t2", instr_at(32'h200), 32'h204, 1'b1);
        held_pc4 = 32'h204;
`else
        exp_ifid("t2", NOP, 32'h10C, 1'b0);
        held_pc4 = 32'h10C;
`endif
        cyc(1'b1, 1'b0, 2'b10, 1'b1, 32'h400);

        // flush without redirect still advances pc
        exp_fetch("flush_seq", 1'b1, 32'h404);
        exp_ifid("flush_seq", NOP, held_pc4, 1'b0);
        cyc(1'b1, 1'b0, 2'b00, 1'b1, 32'h0);
        exp_fetch("jmp300", 1'b1, 32'h300);
        exp_ifid("jmp300", instr_at(32'h404), 32'h408, 1'b1);
        cyc(1'b1, 1'b0, 2'b01, 1'b0, 32'h300);

        // test 3: register jump while memory waits
        exp_fetch("t3.d0", 1'b1, 32'h300);
        exp_ifid("t3.d0", NOP, 32'h408, 1'b0);
        cyc(1'b0, 1'b0, 2'b11, 1'b0, 32'h800);
        exp_fetch("t3.d1", 1'b1, 32'h300);
        exp_ifid("t3.d1", NOP, 32'h408, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        exp_fetch("t3.d2", 1'b1, 32'h300);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        exp_fetch("t3.done", 1'b1, 32'h800);
        exp_ifid("t3.done", NOP, 32'h408, 1'b0);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
        exp_fetch("t3.tgt", 1'b1, 32'h804);
        exp_ifid("t3.tgt", instr_at(32'h800), 32'h804, 1'b1);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);

        // repeated redirects in DRAIN: last one wins
        exp_fetch("lw.d0", 1'b1, 32'h804);
        cyc(1'b0, 1'b0, 2'b01, 1'b0, 32'h900);
        exp_fetch("lw.d1", 1'b1, 32'h804);
        exp_ifid("lw.d1", NOP, 32'h804, 1'b0);
        cyc(1'b0, 1'b0, 2'b10, 1'b0, 32'hA00);
        exp_fetch("lw.done", 1'b1, 32'hA00);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);

        // test 4: data returned during ID stall
        exp_fetch("jmp500", 1'b1, 32'h500);
        exp_ifid("jmp500", instr_at(32'hA00), 32'hA04, 1'b1);
        cyc(1'b1, 1'b0, 2'b01, 1'b0, 32'h500);
        exp_fetch("t4.s0", 1'b0, 32'h500);
        exp_ifid("t4.s0", instr_at(32'hA00), 32'hA04, 1'b1);
        cyc(1'b1, 1'b1, 2'b01, 1'b0, 32'h700);
        exp_fetch("t4.s1", 1'b0, 32'h500);
        exp_ifid("t4.s1", instr_at(32'hA00), 32'hA04, 1'b1);
        cyc(1'b0, 1'b1, 2'b01, 1'b0, 32'h700);
        exp_fetch("t4.rel", 1'b1, 32'h504);
        exp_ifid("t4.rel", instr_at(32'h500), 32'h504, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);

        // stall with memory not ready holds IF/ID
        exp_fetch("stall_wait", 1'b1, 32'h504);
        exp_ifid("stall_wait", instr_at(32'h500), 32'h504, 1'b1);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, 32'h0);

        // HOLD left via redirect without flush loads the buffer
        exp_fetch("hold2", 1'b0, 32'h504);
        cyc(1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        exp_fetch("hold2.jr", 1'b1, 32'h600);
        exp_ifid("hold2.jr", instr_at(32'h504), 32'h508, 1'b1);
        cyc(1'b0, 1'b0, 2'b11, 1'b0, 32'h600);

        // test 5: wrap at top of address space
        exp_fetch("t5.top", 1'b1, 32'hFFFF_FFFC);
        exp_ifid("t5.top", instr_at(32'h600), 32'h604, 1'b1);
        cyc(1'b1, 1'b0, 2'b11, 1'b0, 32'hFFFF_FFFC);
        exp_fetch("t5.wrap", 1'b1, 32'h0);
        exp_ifid("t5.wrap", instr_at(32'hFFFF_FFFC), 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);

        // test 6a: reset in DRAIN
        exp_fetch("t6a.drain", 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 2'b01, 1'b0, 32'h40);
        rst = 1'b1;
        exp_fetch("t6a.rst", 1'b0, RST_PC);
        exp_ifid("t6a.rst", NOP, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
        release_reset("t6a");
        exp_fetch("t6a.boot", 1'b1, RST_PC);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);

        // test 6b: reset in HOLD
        exp_fetch("t6b.f", 1'b1, 32'h104);
        exp_ifid("t6b.f", instr_at(32'h100), 32'h104, 1'b1);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
        exp_fetch("t6b.hold", 1'b0, 32'h104);
        cyc(1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        rst = 1'b1;
        exp_fetch("t6b.rst", 1'b0, RST_PC);
        exp_ifid("t6b.rst", NOP, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        release_reset("t6b");
        exp_fetch("t6b.boot", 1'b1, RST_PC);
        exp_ifid("t6b.boot", NOP, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
        exp_fetch("t6b.f0", 1'b1, 32'h104);
        exp_ifid("t6b.f0", instr_at(32'h100), 32'h104, 1'b1);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
